test_sequencer_gmii: RTL
========================

TEST_SEQUENCER_GMII -- requirements
Module: test_sequencer_gmii

Interface
REQ-001 SHALL have parameter C_GUARD_CYCLES, default 16: cycles the analyzer is enabled before the generator starts.
REQ-002 SHALL have parameter C_DRAIN_CYCLES, default 256: cycles the analyzer stays enabled after the generator stops.
REQ-003 SHALL have parameter C_DUR_WIDTH, default 32: width of the run-duration counter.
REQ-004 SHALL use one clock and an asynchronous, active-low reset.
REQ-005 Ports SHALL be:
- clk  in  1  sole clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- sec  in  48  rtclock seconds.
- nsec  in  30  rtclock nanoseconds, 0..999999999.
- arm  in  1  one-cycle pulse that requests a run.
- abort  in  1  level; terminates any run.
- start_sec  in  48  scheduled start, seconds.
- start_nsec  in  30  scheduled start, nanoseconds.
- duration  in  C_DUR_WIDTH  generator-on time in clk cycles.
- tg_enable  out  1  traffic generator enable.
- ta_enable  out  1  traffic analyzer enable.
- busy  out  1  state is not IDLE and not DONE.
- done  out  1  run completed; held until the next accepted arm.
- late  out  1  start time had already passed when armed.
- aborted  out  1  last run was aborted.
- state  out  3  current state encoding.

Function
REQ-006 States SHALL be IDLE=0, WAIT=1, GUARD=2, RUN=3, DRAIN=4, DONE=5.
REQ-007 An arm pulse in IDLE or DONE SHALL latch start_sec, start_nsec and duration, clear done/late/aborted, and move to WAIT on the next edge.
REQ-008 An arm pulse in WAIT, GUARD, RUN or DRAIN SHALL be ignored with no state or flag change.
REQ-009 In WAIT, the module SHALL compare the 78-bit concatenation {sec,nsec} unsigned against the latched start; when current >= start, it SHALL move to GUARD on that edge.
REQ-010 If current >= start in the first WAIT cycle, late SHALL be set to 1.
REQ-011 GUARD SHALL last exactly C_GUARD_CYCLES cycles with ta_enable=1, tg_enable=0; C_GUARD_CYCLES=0 SHALL go directly to RUN.
REQ-012 RUN SHALL last exactly the latched duration cycles with ta_enable=1, tg_enable=1; duration=0 SHALL skip RUN and go to DRAIN.
REQ-013 DRAIN SHALL last exactly C_DRAIN_CYCLES cycles with ta_enable=1, tg_enable=0, then move to DONE with done=1.
REQ-014 Each phase SHALL use one down-counter of width max(C_DUR_WIDTH, clog2 of the largest guard/drain count); the counter SHALL never wrap.
REQ-015 tg_enable and ta_enable SHALL be registered outputs that change on the same edge as the state they belong to.
REQ-016 abort=1 in any state other than IDLE SHALL, on the next edge, drop tg_enable and ta_enable, move to IDLE, and set aborted=1.
REQ-017 When abort and arm are asserted in the same cycle, abort SHALL win and arm SHALL be ignored.
REQ-018 Changes to start_sec, start_nsec or duration after the run is accepted SHALL NOT affect the run in progress.
REQ-019 A wrap of sec/nsec (nsec going from 999999999 to 0) SHALL need no special handling, because the comparison covers the full concatenation.

Reset
REQ-020 While resetn=0: state=IDLE, tg_enable=0, ta_enable=0, busy=0, done=0, late=0, aborted=0, counter=0, latched config=0.
REQ-021 Reset asserted mid-run SHALL drop both enables immediately (asynchronously); after release the module SHALL remain in IDLE until an arm pulse.

Structure
REQ-022 State encodings and width constants SHALL be kept in the shared package tester_pkg.
REQ-023 The 78-bit >= comparison SHALL be one combinational sub-module, tester_time_cmp, reusable by other schedulers.
REQ-024 The implementation SHALL be one FSM plus one counter, with no AXI logic; configuration arrives from the existing register blocks.

Verification
REQ-025 Scheduled start: start=(5,0), duration=100, rtclock at (4,999999000) -> after arm, ta_enable rises when time reaches (5,0), tg_enable rises 16 cycles later and stays high exactly 100 cycles; done=1 after 256 further cycles.
REQ-026 Late start: start=(0,0) with rtclock at (10,0) -> late=1 and GUARD is entered on the second cycle after arm.
REQ-027 Zero duration: duration=0 -> tg_enable never asserts; ta_enable stays high for exactly 16+256 cycles; done=1.
REQ-028 Abort in RUN at cycle 50 of 100 -> both enables are 0 on the next edge, state=IDLE, aborted=1, done=0.
REQ-029 Arm during RUN plus config change -> run finishes with the original duration; a re-arm from DONE is accepted and clears done.
REQ-030 resetn pulsed low during DRAIN -> enables drop without waiting for a clk edge; all outputs are at reset values; IDLE is held until the next arm.

Source files
------------

// File: rtl/tester_pkg.sv
// Shared definitions for the test sequencer and its helper blocks:
// state encodings, rtclock field widths and a small elaboration helper.
package tester_pkg;

    localparam int SEC_W   = 48;
    localparam int NSEC_W  = 30;
    localparam int TIME_W  = SEC_W + NSEC_W;
    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_GUARD = 3'd2,
        ST_RUN   = 3'd3,
        ST_DRAIN = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tester_time_cmp.sv
// Unsigned "current time has reached start time" comparator over the full
// {sec, nsec} word. Because the whole concatenation is compared, an nsec
// rollover into the next second needs no special handling.
module tester_time_cmp
    import tester_pkg::*;
(
    input  logic [TIME_W-1:0] cur_time,
    input  logic [TIME_W-1:0] start_time,
    output logic              reached
);

    assign reached = (cur_time >= start_time);

endmodule

// File: rtl/test_sequencer_gmii.sv
// Test sequencer for a GMII traffic generator/analyzer pair.
// An accepted arm latches the schedule, waits for the rtclock to reach the
// start time, then opens the analyzer for a guard window, runs the generator
// for the latched duration and keeps the analyzer open for a drain window.
// Phases of zero length are skipped. One down-counter times every phase.
module test_sequencer_gmii
    import tester_pkg::*;
#(
    parameter int C_GUARD_CYCLES = 16,
    parameter int C_DRAIN_CYCLES = 256,
    parameter int C_DUR_WIDTH    = 32
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [SEC_W-1:0]       sec,
    input  logic [NSEC_W-1:0]      nsec,
    input  logic                   arm,
    input  logic                   abort,
    input  logic [SEC_W-1:0]       start_sec,
    input  logic [NSEC_W-1:0]      start_nsec,
    input  logic [C_DUR_WIDTH-1:0] duration,
    output logic                   tg_enable,
    output logic                   ta_enable,
    output logic                   busy,
    output logic                   done,
    output logic                   late,
    output logic                   aborted,
    output logic [STATE_W-1:0]     state
);

    localparam int PHASE_MAX = max_int(C_GUARD_CYCLES, C_DRAIN_CYCLES);
    localparam int CNT_W     = max_int(C_DUR_WIDTH, $clog2(PHASE_MAX + 1));

    localparam logic [CNT_W-1:0] GUARD_LOAD = CNT_W'(C_GUARD_CYCLES);
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(C_DRAIN_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t                 state_q;
    state_t                 state_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic                   first_wait_q;
    logic                   first_wait_d;
    logic                   done_q;
    logic                   done_d;
    logic                   late_q;
    logic                   late_d;
    logic                   aborted_q;
    logic                   aborted_d;
    logic                   tg_q;
    logic                   ta_q;
    logic                   load_cfg;

    logic [SEC_W-1:0]       start_sec_q;
    logic [NSEC_W-1:0]      start_nsec_q;
    logic [C_DUR_WIDTH-1:0] duration_q;

    logic                   reached;

    state_t                 after_run_state;
    state_t                 after_guard_state;
    state_t                 after_wait_state;
    logic [CNT_W-1:0]       after_run_cnt;
    logic [CNT_W-1:0]       after_guard_cnt;
    logic [CNT_W-1:0]       after_wait_cnt;

    tester_time_cmp u_time_cmp (
        .cur_time   ({sec, nsec}),
        .start_time ({start_sec_q, start_nsec_q}),
        .reached    (reached)
    );

    // Resolve the phase that follows each phase, skipping zero-length ones.
    always_comb begin
        after_run_state = ST_DONE;
        after_run_cnt   = '0;
        if (C_DRAIN_CYCLES > 0) begin
            after_run_state = ST_DRAIN;
            after_run_cnt   = DRAIN_LOAD;
        end

        after_guard_state = after_run_state;
        after_guard_cnt   = after_run_cnt;
        if (duration_q != '0) begin
            after_guard_state = ST_RUN;
            after_guard_cnt   = CNT_W'(duration_q);
        end

        after_wait_state = after_guard_state;
        after_wait_cnt   = after_guard_cnt;
        if (C_GUARD_CYCLES > 0) begin
            after_wait_state = ST_GUARD;
            after_wait_cnt   = GUARD_LOAD;
        end
    end

    // Next-state, counter and status-flag logic; abort overrides everything.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        first_wait_d = first_wait_q;
        done_d       = done_q;
        late_d       = late_q;
        aborted_d    = aborted_q;
        load_cfg     = 1'b0;

        if (abort && (state_q != ST_IDLE)) begin
            state_d      = ST_IDLE;
            cnt_d        = '0;
            first_wait_d = 1'b0;
            done_d       = 1'b0;
            aborted_d    = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (arm && !abort) begin
                        load_cfg     = 1'b1;
                        state_d      = ST_WAIT;
                        cnt_d        = '0;
                        first_wait_d = 1'b1;
                        done_d       = 1'b0;
                        late_d       = 1'b0;
                        aborted_d    = 1'b0;
                    end
                end
                ST_WAIT: begin
                    first_wait_d = 1'b0;
                    if (reached) begin
                        late_d  = late_q | first_wait_q;
                        state_d = after_wait_state;
                        cnt_d   = after_wait_cnt;
                    end
                end
                ST_GUARD: begin
                    if (cnt_q <= CNT_ONE) begin
                        state_d = after_guard_state;
                        cnt_d   = after_guard_cnt;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                ST_RUN: begin
                    if (cnt_q <= CNT_ONE) begin
                        state_d = after_run_state;
                        cnt_d   = after_run_cnt;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                ST_DRAIN: begin
                    if (cnt_q <= CNT_ONE) begin
                        state_d = ST_DONE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase

            if ((state_d == ST_DONE) && (state_q != ST_DONE)) begin
                done_d = 1'b1;
            end
        end
    end

    // State, counter, flags and enables; enables follow the next state so
    // they change on the same edge as the state they belong to.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            first_wait_q <= 1'b0;
            done_q       <= 1'b0;
            late_q       <= 1'b0;
            aborted_q    <= 1'b0;
            tg_q         <= 1'b0;
            ta_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            first_wait_q <= first_wait_d;
            done_q       <= done_d;
            late_q       <= late_d;
            aborted_q    <= aborted_d;
            tg_q         <= (state_d == ST_RUN);
            ta_q         <= (state_d == ST_GUARD) || (state_d == ST_RUN) ||
                            (state_d == ST_DRAIN);
        end
    end

    // Schedule snapshot taken when a run is accepted; later input changes
    // cannot disturb the run in progress.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            start_sec_q  <= '0;
            start_nsec_q <= '0;
            duration_q   <= '0;
        end else if (load_cfg) begin
            start_sec_q  <= start_sec;
            start_nsec_q <= start_nsec;
            duration_q   <= duration;
        end
    end

    assign tg_enable = tg_q;
    assign ta_enable = ta_q;
    assign done      = done_q;
    assign late      = late_q;
    assign aborted   = aborted_q;
    assign state     = state_q;
    assign busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);

endmodule
